// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset
// level, FSM state encoding and small helpers for the byte-assembly walk.
package if_fetch_pkg;

  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_BUS_W      = 32;

  // Reset is active when rst equals this level.
  localparam logic RST_ENABLE_N = 1'b0;

  typedef enum logic [2:0] {
    ST_LOOKUP = 3'd0,
    ST_BYTE0  = 3'd1,
    ST_BYTE1  = 3'd2,
    ST_BYTE2  = 3'd3,
    ST_BYTE3  = 3'd4,
    ST_OUT    = 3'd5,
    ST_DRAIN  = 3'd6
  } fetch_state_e;

  // Byte lane (offset inside the word) being fetched in a BYTEk state.
  function automatic logic [1:0] byte_lane(input fetch_state_e st);
    case (st)
      ST_BYTE0: byte_lane = 2'd0;
      ST_BYTE1: byte_lane = 2'd1;
      ST_BYTE2: byte_lane = 2'd2;
      ST_BYTE3: byte_lane = 2'd3;
      default:  byte_lane = 2'd0;
    endcase
  endfunction

  // Successor of a BYTEk state once its byte has been accepted.
  function automatic fetch_state_e next_byte_state(input fetch_state_e st);
    case (st)
      ST_BYTE0: next_byte_state = ST_BYTE1;
      ST_BYTE1: next_byte_state = ST_BYTE2;
      ST_BYTE2: next_byte_state = ST_BYTE3;
      default:  next_byte_state = ST_OUT;
    endcase
  endfunction

endpackage

// File: rtl/if_fetch_icache_dm.sv
// Direct-mapped instruction cache: combinational lookup, synchronous fill,
// valid bits cleared asynchronously by reset. Tag/data storage is not reset
// because a line is never used while its valid bit is clear.
module icache_dm
  import if_fetch_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INST_ADDR_BUS_W-1:0] rd_addr_i,
  output logic                       hit_o,
  output logic [INST_BUS_W-1:0]      data_o,
  input  logic                       we_i,
  input  logic [INST_ADDR_BUS_W-1:0] addr_i,
  input  logic [INST_BUS_W-1:0]      data_i
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = INST_ADDR_BUS_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]      tag_mem_r  [ENTRIES];
  logic [INST_BUS_W-1:0] data_mem_r [ENTRIES];

  logic [IDX_W-1:0] rd_idx_s;
  logic [TAG_W-1:0] rd_tag_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [TAG_W-1:0] wr_tag_s;
  logic             unused_s;

  assign rd_idx_s = rd_addr_i[IDX_W+1:2];
  assign rd_tag_s = rd_addr_i[INST_ADDR_BUS_W-1:IDX_W+2];
  assign wr_idx_s = addr_i[IDX_W+1:2];
  assign wr_tag_s = addr_i[INST_ADDR_BUS_W-1:IDX_W+2];
  // Byte offsets are always zero on word-aligned fetch addresses.
  assign unused_s = ^{rd_addr_i[1:0], addr_i[1:0]};

  assign hit_o  = valid_r[rd_idx_s] && (tag_mem_r[rd_idx_s] == rd_tag_s);
  assign data_o = data_mem_r[rd_idx_s];

  // Valid bits: cleared on reset, set when a line is filled.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE_N) begin
      valid_r <= '0;
    end else if (we_i) begin
      valid_r[wr_idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data storage written on a line fill.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_mem_r[wr_idx_s]  <= wr_tag_s;
      data_mem_r[wr_idx_s] <= data_i;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Looks the pc up in a direct-mapped cache; on a
// miss it reads the word one byte at a time (little-endian) from the memory
// controller, fills the cache and presents pc/inst to decode. Honours the
// downstream stall and branch redirects, draining any in-flight byte request
// before refetching from the new target.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ICACHE_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  fetch_state_e state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic [23:0]  byte_buf_r, byte_buf_s;

  logic         mem_req_s;
  logic [31:0]  mem_addr_s;
  logic         inst_valid_s;
  logic [31:0]  pc_out_s;
  logic [31:0]  inst_s;

  logic         hit_s;
  logic [31:0]  hit_data_s;
  logic         cache_we_s;
  logic [31:0]  cache_wdata_s;
  logic         ack_s;
  logic [1:0]   lane_s;

  // An ack only counts while a request is actually being driven.
  assign ack_s         = mem_ack_i & mem_req_o;
  assign lane_s        = byte_lane(state_r);
  assign cache_wdata_s = {mem_rdata_i, byte_buf_r};

  icache_dm #(
    .IDX_W (ICACHE_IDX_W)
  ) u_icache (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_i (pc_r),
    .hit_o     (hit_s),
    .data_o    (hit_data_s),
    .we_i      (cache_we_s),
    .addr_i    (pc_r),
    .data_i    (cache_wdata_s)
  );

  // Next-state, next-pc, byte assembly and next registered outputs.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    byte_buf_s   = byte_buf_r;
    mem_req_s    = mem_req_o;
    mem_addr_s   = mem_addr_o;
    inst_valid_s = inst_valid_o;
    pc_out_s     = pc_o;
    inst_s       = inst_o;
    cache_we_s   = 1'b0;

    case (state_r)
      ST_LOOKUP: begin
        if (branch_i) begin
          pc_s         = branch_target_i;
          inst_valid_s = 1'b0;
        end else if (hit_s) begin
          inst_valid_s = 1'b1;
          pc_out_s     = pc_r;
          inst_s       = hit_data_s;
          state_s      = ST_OUT;
        end else begin
          mem_req_s    = 1'b1;
          mem_addr_s   = pc_r;
          state_s      = ST_BYTE0;
        end
      end

      ST_BYTE0, ST_BYTE1, ST_BYTE2, ST_BYTE3: begin
        if (branch_i) begin
          // A byte acked in this same cycle completes its request, so nothing
          // is left in flight; otherwise keep the request up until it drains.
          pc_s         = branch_target_i;
          inst_valid_s = 1'b0;
          if (ack_s) begin
            mem_req_s = 1'b0;
            state_s   = ST_LOOKUP;
          end else begin
            state_s   = ST_DRAIN;
          end
        end else if (ack_s) begin
          if (state_r == ST_BYTE3) begin
            cache_we_s   = 1'b1;
            mem_req_s    = 1'b0;
            inst_valid_s = 1'b1;
            pc_out_s     = pc_r;
            inst_s       = cache_wdata_s;
            state_s      = ST_OUT;
          end else begin
            case (lane_s)
              2'd0:    byte_buf_s[7:0]   = mem_rdata_i;
              2'd1:    byte_buf_s[15:8]  = mem_rdata_i;
              2'd2:    byte_buf_s[23:16] = mem_rdata_i;
              default: byte_buf_s        = byte_buf_r;
            endcase
            mem_addr_s = pc_r + {30'd0, lane_s} + 32'd1;
            state_s    = next_byte_state(state_r);
          end
        end else begin
          state_s = state_r;
        end
      end

      ST_OUT: begin
        if (branch_i) begin
          pc_s         = branch_target_i;
          inst_valid_s = 1'b0;
          state_s      = ST_LOOKUP;
        end else if (!stall_i) begin
          pc_s         = pc_r + 32'd4;
          inst_valid_s = 1'b0;
          state_s      = ST_LOOKUP;
        end else begin
          state_s = ST_OUT;
        end
      end

      ST_DRAIN: begin
        // The drained byte is thrown away; a further branch just retargets.
        if (branch_i) begin
          pc_s = branch_target_i;
        end else begin
          pc_s = pc_r;
        end
        if (ack_s) begin
          mem_req_s = 1'b0;
          state_s   = ST_LOOKUP;
        end else begin
          state_s   = ST_DRAIN;
        end
      end

      default: begin
        mem_req_s    = 1'b0;
        inst_valid_s = 1'b0;
        state_s      = ST_LOOKUP;
      end
    endcase
  end

  // State, pc, byte buffer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE_N) begin
      state_r      <= ST_LOOKUP;
      pc_r         <= RESET_PC;
      byte_buf_r   <= 24'd0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= 32'd0;
      inst_valid_o <= 1'b0;
      pc_o         <= 32'd0;
      inst_o       <= 32'd0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      byte_buf_r   <= byte_buf_s;
      mem_req_o    <= mem_req_s;
      mem_addr_o   <= mem_addr_s;
      inst_valid_o <= inst_valid_s;
      pc_o         <= pc_out_s;
      inst_o       <= inst_s;
    end
  end

endmodule
